// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: two-stage pipelined carry-lookahead adder/subtractor with a valid/ready handshake.
// Define CLA_PIPE_SAT_EN to saturate s to the signed range on overflow; otherwise s wraps.
module cla_pipe_adder #(
  parameter int WIDTH = 16  // multiple of 4, 4..64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);
  localparam int NG = WIDTH / 4;

  logic s1_valid_reg;
  logic s2_valid_reg;
  logic adv1;
  logic adv2;

  assign adv2      = ~s2_valid_reg | out_ready;
  assign adv1      = ~s1_valid_reg | adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid_reg;

  // Stage 1: operand conditioning and per-group generate/propagate
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] g_bit;
  logic [WIDTH-1:0] p_bit;
  logic             c0;
  logic [NG-1:0]    g_grp;
  logic [NG-1:0]    p_grp;

  assign b_eff = sub ? ~b : b;
  assign c0    = sub | ci;
  assign g_bit = a & b_eff;
  assign p_bit = a | b_eff;

  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_s1_grp
      localparam int B = 4 * gi;
      assign g_grp[gi] = g_bit[B+3]
                       | (p_bit[B+3] & g_bit[B+2])
                       | (p_bit[B+3] & p_bit[B+2] & g_bit[B+1])
                       | (p_bit[B+3] & p_bit[B+2] & p_bit[B+1] & g_bit[B]);
      assign p_grp[gi] = &p_bit[B+3:B];
    end
  endgenerate

  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_bp_reg;
  logic             s1_c0_reg;
  logic [NG-1:0]    s1_g_reg;
  logic [NG-1:0]    s1_p_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_bp_reg    <= '0;
      s1_c0_reg    <= 1'b0;
      s1_g_reg     <= '0;
      s1_p_reg     <= '0;
    end else begin
      if (adv1) s1_valid_reg <= in_valid;
      if (adv1 && in_valid) begin
        s1_a_reg  <= a;
        s1_bp_reg <= b_eff;
        s1_c0_reg <= c0;
        s1_g_reg  <= g_grp;
        s1_p_reg  <= p_grp;
      end
    end
  end

  // Stage 2: group carries as flat sum-of-products, no ripple through groups
  logic [NG:0] c_grp;
  logic        la_term;
  logic        la_acc;

  always_comb begin
    c_grp    = '0;
    la_term  = 1'b0;
    la_acc   = 1'b0;
    c_grp[0] = s1_c0_reg;
    for (int k = 0; k < NG; k++) begin
      la_acc = 1'b0;
      for (int j = 0; j <= k; j++) begin
        la_term = s1_g_reg[j];
        for (int m = j + 1; m <= k; m++) la_term = la_term & s1_p_reg[m];
        la_acc = la_acc | la_term;
      end
      la_term = s1_c0_reg;
      for (int m = 0; m <= k; m++) la_term = la_term & s1_p_reg[m];
      c_grp[k+1] = la_acc | la_term;
    end
  end

  logic [WIDTH-1:0] g2_bit;
  logic [WIDTH-1:0] p2_bit;
  logic [WIDTH-1:0] c_bit;
  logic [WIDTH-1:0] sum;

  assign g2_bit = s1_a_reg & s1_bp_reg;
  assign p2_bit = s1_a_reg | s1_bp_reg;

  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_s2_bit
      localparam int B = 4 * gi;
      assign c_bit[B]   = c_grp[gi];
      assign c_bit[B+1] = g2_bit[B] | (p2_bit[B] & c_grp[gi]);
      assign c_bit[B+2] = g2_bit[B+1]
                        | (p2_bit[B+1] & g2_bit[B])
                        | (p2_bit[B+1] & p2_bit[B] & c_grp[gi]);
      assign c_bit[B+3] = g2_bit[B+2]
                        | (p2_bit[B+2] & g2_bit[B+1])
                        | (p2_bit[B+2] & p2_bit[B+1] & g2_bit[B])
                        | (p2_bit[B+2] & p2_bit[B+1] & p2_bit[B] & c_grp[gi]);
    end
  endgenerate

  logic [WIDTH-1:0] s_next;
  logic             ovf_next;
  logic             zero_next;

  assign sum      = s1_a_reg ^ s1_bp_reg ^ c_bit;
  assign ovf_next = c_bit[WIDTH-1] ^ c_grp[NG];

`ifdef CLA_PIPE_SAT_EN
  // Overflow direction follows the sign of a: both operands share it when overflow occurs
  always_comb begin
    s_next = sum;
    if (ovf_next) begin
      s_next = s1_a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign s_next = sum;
`endif

  assign zero_next = ~|s_next;

  logic [WIDTH-1:0] s_reg;
  logic             co_reg;
  logic             ovf_reg;
  logic             zero_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_reg <= 1'b0;
      s_reg        <= '0;
      co_reg       <= 1'b0;
      ovf_reg      <= 1'b0;
      zero_reg     <= 1'b0;
    end else begin
      if (adv2) s2_valid_reg <= s1_valid_reg;
      if (adv2 && s1_valid_reg) begin
        s_reg    <= s_next;
        co_reg   <= c_grp[NG];
        ovf_reg  <= ovf_next;
        zero_reg <= zero_next;
      end
    end
  end

  assign s    = s_reg;
  assign co   = co_reg;
  assign ovf  = ovf_reg;
  assign zero = zero_reg;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=16): scoreboard of arithmetic-model results,
// handshake/stall monitor, directed vectors, backpressure, mid-stream reset and throughput.
module tb_cla_pipe_adder;
  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
    logic         zero;
  } res_t;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         co;
  logic         ovf;
  logic         zero;

  cla_pipe_adder #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   in_cyc = 0;
  int   out_cyc = 0;
  int   n_out = 0;
  int   stall_cycles = 0;
  int   or_mode = 0;
  int   pidx = 0;
  bit   pat [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  res_t q [$];
  logic held = 1'b0;
  res_t held_v;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                 input logic tci, input logic tsub);
    logic [W-1:0] bp;
    logic [W:0]   full;
    res_t         r;
    bp    = tsub ? ~tb_ : tb_;
    full  = {1'b0, ta} + {1'b0, bp} + {{W{1'b0}}, (tsub | tci)};
    r.s   = full[W-1:0];
    r.co  = full[W];
    r.ovf = (ta[W-1] == bp[W-1]) && (r.s[W-1] != ta[W-1]);
`ifdef CLA_PIPE_SAT_EN
    if (r.ovf) r.s = ta[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    r.zero = (r.s == '0);
    return r;
  endfunction

  function automatic res_t mk(input logic [W-1:0] es, input logic eco, input logic eovf);
    res_t r;
    r.s = es; r.co = eco; r.ovf = eovf; r.zero = (es == '0);
    return r;
  endfunction

  // Monitor: handshake rule, stall stability and in-order scoreboard comparison
  always @(negedge clk) begin
    res_t e;
    if (!reset_n) begin
      held = 1'b0;
    end else begin
      checks++;
      assert (in_ready === !(q.size() >= 2 && !out_ready)) else begin
        errors++;
        $error("FAIL in_ready: got %b expected %b (in flight %0d)", in_ready,
               !(q.size() >= 2 && !out_ready), q.size());
      end
      if (!in_ready) stall_cycles++;
      if (held) begin
        checks++;
        assert ({out_valid, s, co, ovf, zero} === {1'b1, held_v}) else begin
          errors++;
          $error("FAIL stall_hold: got v=%b %h/%b/%b/%b expected v=1 %h/%b/%b/%b",
                 out_valid, s, co, ovf, zero, held_v.s, held_v.co, held_v.ovf, held_v.zero);
        end
      end
      held   = out_valid && !out_ready;
      held_v = {s, co, ovf, zero};
      if (out_valid && out_ready) begin
        checks++;
        assert (q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_output: got s=%h with 0 expected beats", s);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          checks++;
          assert (s === e.s) else begin errors++; $error("FAIL s: got %h expected %h", s, e.s); end
          checks++;
          assert (co === e.co) else begin errors++; $error("FAIL co: got %b expected %b", co, e.co); end
          checks++;
          assert (ovf === e.ovf) else begin errors++; $error("FAIL ovf: got %b expected %b", ovf, e.ovf); end
          checks++;
          assert (zero === e.zero) else begin errors++; $error("FAIL zero: got %b expected %b", zero, e.zero); end
          $display("result s=%h co=%b ovf=%b zero=%b", s, co, ovf, zero);
          out_cyc = cyc;
          n_out++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (or_mode == 1) begin
      out_ready = pat[pidx % 6];
      pidx++;
    end else if (or_mode == 2) begin
      out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_item(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                           input logic tci, input logic tsub, input res_t e);
    bit accepted;
    accepted = 1'b0;
    a = ta; b = tb_; ci = tci; sub = tsub; in_valid = 1'b1;
    for (int n = 0; n < 100 && !accepted; n++) begin
      @(negedge clk);
      #1;
      if (in_ready) begin
        q.push_back(e);
        in_cyc   = cyc;
        accepted = 1'b1;
        $display("beat a=%h b=%h ci=%b sub=%b", ta, tb_, tci, tsub);
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    assert (accepted) else begin errors++; $error("FAIL accept_timeout: got no in_ready expected acceptance"); end
  endtask

  task automatic send_rand(input bit rnd_op);
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;
    ra = W'($urandom);
    rb = W'($urandom);
    rc = rnd_op ? 1'($urandom_range(0, 1)) : 1'b0;
    rs = rnd_op ? 1'($urandom_range(0, 1)) : 1'b0;
    send_item(ra, rb, rc, rs, model(ra, rb, rc, rs));
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && q.size() != 0; n++) step();
    checks++;
    assert (q.size() == 0) else begin errors++; $error("FAIL drain: got %0d pending expected 0", q.size()); end
  endtask

  initial begin
    int t0;
    int n0;
    int st0;
    clk = 1'b0; reset_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    assert ({out_valid, s, co, ovf, zero, in_ready} === {1'b0, {W{1'b0}}, 3'b000, 1'b1}) else begin
      errors++;
      $error("FAIL reset_state: got v=%b s=%h co=%b ovf=%b z=%b rdy=%b expected 0/0/0/0/0/1",
             out_valid, s, co, ovf, zero, in_ready);
    end
    reset_n = 1'b1;

    // Carry through every group, then isolated-beat latency
    send_item(16'hFFFF, 16'h0000, 1'b1, 1'b0, mk(16'h0000, 1'b1, 1'b0));
    drain();
    checks++;
    assert (out_cyc - in_cyc == 2) else begin
      errors++; $error("FAIL latency: got %0d expected 2", out_cyc - in_cyc);
    end

    send_item(16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
`ifdef CLA_PIPE_SAT_EN
    send_item(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h8000, 1'b1, 1'b1));
    send_item(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h7FFF, 1'b0, 1'b1));
`else
    send_item(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
    send_item(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
`endif
    send_item(16'h0005, 16'h0003, 1'b1, 1'b1, mk(16'h0002, 1'b1, 1'b0));
    send_item(16'h1234, 16'h1234, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b0));
    drain();

    // Backpressure on a fixed out_ready pattern
    st0 = stall_cycles;
    or_mode = 1; pidx = 0;
    for (int i = 0; i < 8; i++) send_rand(1'b0);
    or_mode = 0; out_ready = 1'b1;
    drain();
    checks++;
    assert (stall_cycles > st0) else begin
      errors++; $error("FAIL backpressure_stall: got %0d stall cycles expected >0", stall_cycles - st0);
    end

    // Reset with two beats in flight
    out_ready = 1'b0;
    send_rand(1'b1);
    send_rand(1'b1);
    reset_n = 1'b0;
    #1;
    checks++;
    assert ({out_valid, s, in_ready} === {1'b0, {W{1'b0}}, 1'b1}) else begin
      errors++;
      $error("FAIL mid_reset: got v=%b s=%h rdy=%b expected v=0 s=0 rdy=1", out_valid, s, in_ready);
    end
    q.delete();
    step();
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) step();
    checks++;
    assert (out_valid === 1'b0) else begin
      errors++; $error("FAIL stale_after_reset: got out_valid=%b expected 0", out_valid);
    end

    // Random operations under random backpressure
    or_mode = 2;
    for (int i = 0; i < 40; i++) send_rand(1'b1);
    or_mode = 0; out_ready = 1'b1;
    drain();

    // Sustained throughput
    n0 = n_out;
    send_rand(1'b1);
    t0 = in_cyc;
    for (int i = 1; i < 100; i++) send_rand(1'b1);
    drain();
    checks++;
    assert (n_out - n0 == 100 && out_cyc - t0 + 1 == 102) else begin
      errors++;
      $error("FAIL throughput: got %0d results in %0d cycles expected 100 in 102",
             n_out - n0, out_cyc - t0 + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected $finish");
    $fatal(1, "timeout");
  end

endmodule
